// File: rtl/pc_gen.sv
// Fetch program-counter generator: picks the next PC from exception, redirect, held redirect,
// call target, return-address-stack prediction or sequential increment.
module pc_gen #(
  parameter int unsigned     WORD      = 32,
  parameter int unsigned     INC       = 4,
  parameter logic [WORD-1:0] RESET_VEC = '0,
  parameter logic [WORD-1:0] EXC_VEC   = WORD'(32'h8000_0180),
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PCWrite,
  input  logic            exc_valid,
  input  logic            redirect_valid,
  input  logic [WORD-1:0] redirect_target,
  input  logic            call_valid,
  input  logic [WORD-1:0] call_target,
  input  logic            ret_valid,
  output logic [WORD-1:0] curr,
  output logic [WORD-1:0] curr_plus,
  output logic            pend_valid,
  output logic            ras_empty
);

  localparam int unsigned     PW    = $clog2(RAS_DEPTH);
  localparam int unsigned     CW    = $clog2(RAS_DEPTH + 1);
  localparam logic [WORD-1:0] INC_W = WORD'(INC);

  logic [WORD-1:0] curr_q, curr_d;
  logic            pend_valid_q, pend_valid_d;
  logic [WORD-1:0] pend_target_q, pend_target_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   top_q, top_d;
  logic            ras_empty_q;
  logic            push;
  logic [WORD-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]   top_idx;

  assign curr_plus = curr_q + INC_W;
  // top_q is the next free slot; the most recent entry sits one below it
  assign top_idx   = top_q - PW'(1);

  // Next-PC selection in strict priority order
  always_comb begin
    curr_d        = curr_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    cnt_d         = cnt_q;
    top_d         = top_q;
    push          = 1'b0;
    if (exc_valid) begin
      curr_d       = EXC_VEC;
      pend_valid_d = 1'b0;
      cnt_d        = '0;
    end else if (redirect_valid && PCWrite) begin
      curr_d       = redirect_target;
      pend_valid_d = 1'b0;
    end else if (redirect_valid) begin
      pend_valid_d  = 1'b1;
      pend_target_d = redirect_target;
    end else if (!PCWrite) begin
      curr_d = curr_q;
    end else if (pend_valid_q) begin
      curr_d       = pend_target_q;
      pend_valid_d = 1'b0;
    end else if (call_valid) begin
      curr_d = call_target;
      push   = 1'b1;
      top_d  = top_q + PW'(1);
      cnt_d  = (cnt_q == CW'(RAS_DEPTH)) ? cnt_q : cnt_q + CW'(1);
    end else if (ret_valid && (cnt_q != '0)) begin
      curr_d = ras_q[top_idx];
      top_d  = top_idx;
      cnt_d  = cnt_q - CW'(1);
    end else begin
      curr_d = curr_plus;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      curr_q        <= RESET_VEC;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      cnt_q         <= '0;
      top_q         <= '0;
      ras_empty_q   <= 1'b1;
    end else begin
      curr_q        <= curr_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      cnt_q         <= cnt_d;
      top_q         <= top_d;
      ras_empty_q   <= (cnt_d == '0);
    end
  end

  // Stack storage needs no reset: an empty count makes stale entries unreachable
  always_ff @(posedge clk) begin
    if (push) begin
      ras_q[top_q] <= curr_plus;
    end
  end

  assign curr       = curr_q;
  assign pend_valid = pend_valid_q;
  assign ras_empty  = ras_empty_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: a 32-bit instance for the main scenarios and an 8-bit
// instance for wrap-around; expected outputs are queued per cycle and checked by a monitor.
module tb_pc_gen;

  typedef struct {
    logic        dut8;
    logic [31:0] curr;
    logic        pend;
    logic        empty;
    int          id;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pcw = 1'b0;
  logic        exc = 1'b0;
  logic        rdv = 1'b0;
  logic [31:0] rdt = '0;
  logic        cv = 1'b0;
  logic [31:0] ct = '0;
  logic        rv = 1'b0;
  logic [7:0]  rdt8, ct8;

  logic [31:0] curr32, plus32;
  logic        pend32, empty32;
  logic [7:0]  curr8, plus8;
  logic        pend8, empty8;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   step_id = 0;

  assign rdt8 = rdt[7:0];
  assign ct8  = ct[7:0];

  always #5 clk = ~clk;

  pc_gen #(.WORD(32), .INC(4), .RESET_VEC(32'h0), .EXC_VEC(32'h8000_0180), .RAS_DEPTH(4)) u32 (
    .clk(clk), .reset(reset), .PCWrite(pcw), .exc_valid(exc),
    .redirect_valid(rdv), .redirect_target(rdt),
    .call_valid(cv), .call_target(ct), .ret_valid(rv),
    .curr(curr32), .curr_plus(plus32), .pend_valid(pend32), .ras_empty(empty32)
  );

  pc_gen #(.WORD(8), .INC(4), .RESET_VEC(8'h0), .EXC_VEC(8'h80), .RAS_DEPTH(4)) u8 (
    .clk(clk), .reset(reset), .PCWrite(pcw), .exc_valid(exc),
    .redirect_valid(rdv), .redirect_target(rdt8),
    .call_valid(cv), .call_target(ct8), .ret_valid(rv),
    .curr(curr8), .curr_plus(plus8), .pend_valid(pend8), .ras_empty(empty8)
  );

  task automatic cmp(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s step%0d: got 0x%08h expected 0x%08h", name, id, act, req);
    end
  endtask

  // Monitor: outputs are valid every cycle, so one queued expectation is consumed per edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.dut8) begin
        cmp("curr8", e.id, {24'h0, curr8}, e.curr & 32'hFF);
        cmp("curr_plus8", e.id, {24'h0, plus8}, (e.curr + 32'd4) & 32'hFF);
        cmp("pend8", e.id, {31'h0, pend8}, {31'h0, e.pend});
        cmp("empty8", e.id, {31'h0, empty8}, {31'h0, e.empty});
      end else begin
        cmp("curr", e.id, curr32, e.curr);
        cmp("curr_plus", e.id, plus32, e.curr + 32'd4);
        cmp("pend_valid", e.id, {31'h0, pend32}, {31'h0, e.pend});
        cmp("ras_empty", e.id, {31'h0, empty32}, {31'h0, e.empty});
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the following edge
  task automatic step(input logic i_rst, input logic i_pcw, input logic i_exc,
                      input logic i_rdv, input logic [31:0] i_rdt,
                      input logic i_cv, input logic [31:0] i_ct, input logic i_rv,
                      input logic d8, input logic [31:0] e_curr, input logic e_pend, input logic e_empty);
    exp_t e;
    @(negedge clk);
    reset = i_rst; pcw = i_pcw; exc = i_exc;
    rdv = i_rdv; rdt = i_rdt; cv = i_cv; ct = i_ct; rv = i_rv;
    step_id++;
    e.dut8 = d8; e.curr = e_curr; e.pend = e_pend; e.empty = e_empty; e.id = step_id;
    sb.push_back(e);
    @(posedge clk);
  endtask

  initial begin
    int budget;
    // T1: reset then sequential fetch
    step(1,1,0, 0,0, 0,0,0, 0, 32'h0,   0,1);
    step(1,1,0, 0,0, 0,0,0, 0, 32'h0,   0,1);
    step(0,1,0, 0,0, 0,0,0, 0, 32'h4,   0,1);
    step(0,1,0, 0,0, 0,0,0, 0, 32'h8,   0,1);
    step(0,1,0, 0,0, 0,0,0, 0, 32'hC,   0,1);
    step(0,1,0, 0,0, 0,0,0, 0, 32'h10,  0,1);
    // T2: redirect during stall is held and applied on release
    step(0,0,0, 1,32'h200, 0,0,0, 0, 32'h10, 1,1);
    step(0,0,0, 0,0,       0,0,0, 0, 32'h10, 1,1);
    step(0,0,0, 0,0,       0,0,0, 0, 32'h10, 1,1);
    step(0,1,0, 0,0,       0,0,0, 0, 32'h200,0,1);
    step(0,1,0, 0,0,       0,0,0, 0, 32'h204,0,1);
    // T3: a live redirect beats the held one
    step(0,0,0, 1,32'h200, 0,0,0, 0, 32'h204,1,1);
    step(0,1,0, 1,32'h300, 0,0,0, 0, 32'h300,0,1);
    step(0,1,0, 0,0,       0,0,0, 0, 32'h304,0,1);
    // T4: five calls overflow a 4-deep stack, then five returns
    step(1,1,0, 0,0, 0,0,0, 0, 32'h0, 0,1);
    step(0,1,0, 0,0, 1,32'h100,0, 0, 32'h100,0,0);
    step(0,1,0, 0,0, 1,32'h200,0, 0, 32'h200,0,0);
    step(0,1,0, 0,0, 1,32'h300,0, 0, 32'h300,0,0);
    step(0,1,0, 0,0, 1,32'h400,0, 0, 32'h400,0,0);
    step(0,1,0, 0,0, 1,32'h500,0, 0, 32'h500,0,0);
    step(0,1,0, 0,0, 0,0,1, 0, 32'h404,0,0);
    step(0,1,0, 0,0, 0,0,1, 0, 32'h304,0,0);
    step(0,1,0, 0,0, 0,0,1, 0, 32'h204,0,0);
    step(0,1,0, 0,0, 0,0,1, 0, 32'h104,0,1);
    step(0,1,0, 0,0, 0,0,1, 0, 32'h108,0,1);
    // T5: exception during stall with a held redirect and two stack entries
    step(0,1,0, 0,0,       1,32'h600,0, 0, 32'h600,0,0);
    step(0,1,0, 0,0,       1,32'h700,0, 0, 32'h700,0,0);
    step(0,0,0, 1,32'h900, 0,0,0,       0, 32'h700,1,0);
    step(0,0,1, 0,0,       0,0,0,       0, 32'h8000_0180,0,1);
    step(0,1,0, 0,0,       0,0,0,       0, 32'h8000_0184,0,1);
    step(0,1,0, 0,0,       0,0,1,       0, 32'h8000_0188,0,1);
    // T6b: call and ret together push only; the next ret pops that entry
    step(0,1,0, 0,0, 1,32'h1000,1, 0, 32'h1000,0,0);
    step(0,1,0, 0,0, 0,0,1,        0, 32'h8000_018C,0,1);
    // Redirect outranks a call and leaves the stack alone
    step(0,1,0, 1,32'h40, 1,32'h50,0, 0, 32'h40,0,1);
    // Stall ignores call; then reset mid-operation clears pending and stack
    step(0,0,0, 0,0,       1,32'h2000,0, 0, 32'h40,0,1);
    step(0,1,0, 0,0,       1,32'h2000,0, 0, 32'h2000,0,0);
    step(0,0,0, 1,32'h3000,0,0,0,        0, 32'h2000,1,0);
    step(1,0,0, 0,0,       0,0,0,        0, 32'h0,0,1);
    step(0,1,0, 0,0,       0,0,1,        0, 32'h4,0,1);
    // T6a: 8-bit instance wraps from 0xFC to 0x00
    step(1,1,0, 0,0,      0,0,0, 1, 32'h00,0,1);
    step(0,1,0, 1,32'hF8, 0,0,0, 1, 32'hF8,0,1);
    step(0,1,0, 0,0,      0,0,0, 1, 32'hFC,0,1);
    step(0,1,0, 0,0,      0,0,0, 1, 32'h00,0,1);
    step(0,1,0, 0,0,      0,0,0, 1, 32'h04,0,1);
    budget = 20;
    while (sb.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
